// File: rtl/weighted_rr_scheduler.sv
// Weighted round-robin read scheduler for a bank of output FIFOs.
// Grants one queue at a time and pops it for up to its programmed weight.
module weighted_rr_scheduler #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int WEIGHT_BITS    = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enb,
  input  logic [QUEUE_QUANTITY-1:0]             buf_empty,
  input  logic                                  dst_full,
  input  logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] weights,
  output logic [QUEUE_QUANTITY-1:0]             pop,
  output logic [$clog2(QUEUE_QUANTITY)-1:0]     selector,
  output logic                                  selector_enb,
  output logic                                  busy
);

  localparam int SEL_W = $clog2(QUEUE_QUANTITY);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [SEL_W-1:0]        r_sel, w_sel_nxt;
  logic [SEL_W-1:0]        r_ptr, w_ptr_nxt;
  logic [WEIGHT_BITS-1:0]  r_credit, w_credit_nxt;

  logic [QUEUE_QUANTITY-1:0] w_eligible;
  logic                      w_any_eligible;
  logic [SEL_W-1:0]          w_scan_idx;
  logic [SEL_W-1:0]          w_grant_idx;
  logic [WEIGHT_BITS-1:0]    w_grant_weight;
  logic [SEL_W-1:0]          w_sel_inc;
  logic                      w_popping;

  // A queue competes only if it holds data and is not masked by a zero weight.
  always_comb begin
    w_eligible = {QUEUE_QUANTITY{1'b0}};
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      w_eligible[i] = !buf_empty[i] &&
                      (weights[i*WEIGHT_BITS +: WEIGHT_BITS] != {WEIGHT_BITS{1'b0}});
    end
  end

  assign w_any_eligible = |w_eligible;

  // Descending scan so the eligible queue nearest to ptr (mod N) wins.
  always_comb begin
    w_grant_idx = r_ptr;
    w_scan_idx  = r_ptr;
    for (int k = QUEUE_QUANTITY - 1; k >= 0; k--) begin
      w_scan_idx = r_ptr + SEL_W'(k);
      if (w_eligible[w_scan_idx]) begin
        w_grant_idx = w_scan_idx;
      end else begin
        w_grant_idx = w_grant_idx;
      end
    end
  end

  // Weight of the queue about to be granted, loaded into credit at the grant edge.
  always_comb begin
    w_grant_weight = {WEIGHT_BITS{1'b0}};
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      if (w_grant_idx == SEL_W'(i)) begin
        w_grant_weight = weights[i*WEIGHT_BITS +: WEIGHT_BITS];
      end else begin
        w_grant_weight = w_grant_weight;
      end
    end
  end

  assign w_sel_inc = r_sel + SEL_W'(1);
  assign w_popping = (r_state == ST_SERVE) && enb && !dst_full && !buf_empty[r_sel];

  // Mealy outputs: pops follow enb/dst_full/buf_empty in the same cycle.
  always_comb begin
    pop          = {QUEUE_QUANTITY{1'b0}};
    selector     = r_sel;
    selector_enb = 1'b0;
    busy         = 1'b0;
    if (r_state == ST_SERVE) begin
      busy = 1'b1;
      if (w_popping) begin
        pop          = QUEUE_QUANTITY'(1) << r_sel;
        selector_enb = 1'b1;
      end else begin
        pop          = {QUEUE_QUANTITY{1'b0}};
        selector_enb = 1'b0;
      end
    end else begin
      busy = 1'b0;
    end
  end

  // Next-state: grant in IDLE, spend credit in SERVE, leave on exhaustion or drain.
  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_ptr_nxt    = r_ptr;
    w_credit_nxt = r_credit;
    case (r_state)
      ST_IDLE: begin
        if (enb && w_any_eligible) begin
          w_sel_nxt    = w_grant_idx;
          w_credit_nxt = w_grant_weight;
          w_state_nxt  = ST_SERVE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (w_popping) begin
          if (r_credit <= WEIGHT_BITS'(1)) begin
            w_credit_nxt = {WEIGHT_BITS{1'b0}};
            w_ptr_nxt    = w_sel_inc;
            w_state_nxt  = ST_IDLE;
          end else begin
            w_credit_nxt = r_credit - WEIGHT_BITS'(1);
          end
        end else if (enb && buf_empty[r_sel]) begin
          w_credit_nxt = {WEIGHT_BITS{1'b0}};
          w_ptr_nxt    = w_sel_inc;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_state_nxt = ST_SERVE;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_credit_nxt = {WEIGHT_BITS{1'b0}};
      end
    endcase
  end

  // State and arbitration registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_sel    <= {SEL_W{1'b0}};
      r_ptr    <= {SEL_W{1'b0}};
      r_credit <= {WEIGHT_BITS{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_ptr    <= w_ptr_nxt;
      r_credit <= w_credit_nxt;
    end
  end

endmodule

// File: doc/weighted_rr_scheduler.md
Name: weighted_rr_scheduler

Overview:
- Weighted round-robin read scheduler for the bank of QUEUE_QUANTITY output FIFOs.
- Grants one FIFO at a time and serves it for a burst of up to its programmed weight, issuing one-hot pop strobes.
- Drives selector/selector_enb to the output data mux, and stalls on downstream full.
- Sits between the FIFO bank and the egress port; it supersedes the plain round-robin selector where per-queue bandwidth shares are needed.

Parameters:
- QUEUE_QUANTITY, 4, number of FIFOs arbitrated (power of 2, ≥2).
- WEIGHT_BITS, 3, width of each per-queue weight (max burst 2^WEIGHT_BITS-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- enb  input  1  block enable; low freezes state and suppresses pops.
- buf_empty  input  QUEUE_QUANTITY  per-FIFO empty flags, bit i = FIFO i.
- dst_full  input  1  downstream full; high suppresses pops.
- weights  input  QUEUE_QUANTITY*WEIGHT_BITS  weight of queue i at bits [i*WEIGHT_BITS +: WEIGHT_BITS]; 0 = queue masked.
- pop  output  QUEUE_QUANTITY  one-hot FIFO read strobe.
- selector  output  clog2(QUEUE_QUANTITY)  index of granted queue.
- selector_enb  output  1  high in any cycle where pop is nonzero.
- busy  output  1  high while in SERVE.

Behaviour:
- Registers:
  - state ∈ {IDLE, SERVE}
  - sel (granted index)
  - ptr (arbitration start index)
  - credit (WEIGHT_BITS wide)
- Reset (rst=0, async): state=IDLE, sel=0, ptr=0, credit=0. Outputs pop=0, selector=0, selector_enb=0, busy=0, immediately and independent of clk.
- Eligibility: eligible[i] = !buf_empty[i] && weights[i]!=0.
- IDLE, on clk edge with enb=1 and any eligible queue:
  - sel ← first eligible index scanning ptr, ptr+1, … with wrap modulo QUEUE_QUANTITY.
  - credit ← weights[sel], sampled only at this edge.
  - state ← SERVE.
- IDLE otherwise: hold.
- SERVE outputs (Mealy):
  - popping = enb && !dst_full && !buf_empty[sel].
  - pop = popping ? (1<<sel) : 0.
  - selector_enb = popping.
  - selector = sel; sel holds its value while in IDLE.
  - busy = 1.
- SERVE transitions, at clk edge:
  - popping && credit==1 → credit←0, ptr←sel+1 (wrap), state←IDLE.
  - popping && credit>1 → credit←credit-1, stay.
  - !popping && enb && buf_empty[sel] (queue drained early) → ptr←sel+1 (wrap), state←IDLE, remaining credit discarded.
  - !popping otherwise (enb=0 or dst_full=1) → hold all state and credit.
- Latency:
  - First pop occurs in the cycle after the IDLE edge that grants.
  - Between bursts there is always exactly one IDLE bubble cycle with pop=0.
- Weight changes mid-burst have no effect until the next grant.
- Weight 0 on a non-empty queue: never granted; if all non-empty queues are masked, remain IDLE.
- At most one pop bit is ever high. A pop is never issued to an empty FIFO, nor while dst_full=1.
- Pointer wrap: sel=QUEUE_QUANTITY-1 sets ptr←0.
- Reset mid-burst: pop drops to 0 asynchronously. After release, arbitration restarts from ptr=0 with the burst discarded.

Test Plan:
1. Reset: hold rst=0 with all buf_empty=0, weights all 1 → pop=0, selector=0, selector_enb=0, busy=0. Release rst → first pop=4'b0001 two edges later (IDLE grant edge, then SERVE cycle).
2. Equal weights (all 1), all FIFOs deep and non-empty, dst_full=0 → pops in order q0,q1,q2,q3,q0, one pop every other cycle; selector = 0,1,2,3,0 during pop cycles.
3. Weights q0=3, q1=1, q2=2, q3=0, all non-empty → pop sequence q0,q0,q0,q1,q2,q2,q0,…; pop[3] never asserts.
4. Backpressure: q0 weight 3. After the first q0 pop, dst_full=1 for 4 cycles → pop=0, selector held 0, busy=1. After release, exactly 2 more q0 pops, then a bubble, then q1.
5. Early empty: q1 weight 4 holding 2 entries → 2 pops of q1. buf_empty[1] rises, then IDLE for one cycle, then q2 is granted; q1 is not revisited before q2, q3, q0.
6. Async reset mid-burst: drive rst low between edges during a q2 weight-3 burst → pop=0 and busy=0 without a clock. After release, the first grant is q0 (ptr=0).
